// File: rtl/load_stage.sv
// Keccak load stage: packs 64-bit header/message words into rate blocks
// and appends SHAKE padding, handing each block to the permute stage.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   data_in/valid/ready       word stream; first word of a message is the header
//                             {mode[63:62], length_bytes[61:32], output_size[31:0]}
//   rate_output               assembled block, byte k at [8k+7:8k]
//   output_size, operation_mode, copy_control_regs_en
//                             latched header fields and their one-cycle strobe
//   input_buffer_ready(_clr)  block-held flag and its consumer clear
//   last_block_in_buffer(_clr) final-block flag and its consumer clear

package keccak_pkg;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;
    localparam int WORD_W        = 64;
    localparam int BYTES_128     = RATE_SHAKE128 / 8;
    localparam int BYTES_256     = RATE_SHAKE256 / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2
    } load_state_t;
endpackage

module load_stage
    import keccak_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_W-1:0]        data_in,
    input  logic                     data_valid,
    output logic                     data_ready,
    output logic [RATE_SHAKE128-1:0] rate_output,
    output logic [31:0]              output_size,
    output logic [1:0]               operation_mode,
    output logic                     copy_control_regs_en,
    output logic                     input_buffer_ready,
    output logic                     last_block_in_buffer,
    input  logic                     input_buffer_ready_clr,
    input  logic                     last_block_in_buffer_clr
);

    load_state_t state, state_n;

    logic [29:0] remaining, remaining_n;
    logic [7:0]  byte_idx, byte_idx_n;
    logic [4:0]  word_idx, word_idx_n;

    logic [RATE_SHAKE128-1:0] rate_n;
    logic [31:0] size_n;
    logic [1:0]  mode_n;
    logic        copy_n;
    logic        ibr_n;
    logic        lbb_n;

    logic hdr_acc;
    logic load_acc;
    logic pad_fire;

    logic [1:0]  hdr_mode;
    logic [29:0] hdr_len;
    logic [31:0] hdr_size;

    logic [7:0]  rate_bytes;
    logic [7:0]  last_byte;
    logic [3:0]  take;
    logic [7:0]  byte_next;
    logic [29:0] rem_after;
    logic        block_full;

    logic [WORD_W-1:0] word_masked;
    logic [10:0] word_base;
    logic [10:0] pad_base;
    logic [10:0] end_base;

    assign hdr_mode = data_in[63:62];
    assign hdr_len  = data_in[61:32];
    assign hdr_size = data_in[31:0];

    // Any mode other than 00 runs at the SHAKE256 rate.
    assign rate_bytes = (operation_mode == 2'b00) ?
                        8'(BYTES_128) : 8'(BYTES_256);
    assign last_byte  = rate_bytes - 8'd1;

    assign take       = (remaining < 30'd8) ? remaining[3:0] : 4'd8;
    assign byte_next  = byte_idx + {4'd0, take};
    assign rem_after  = remaining - {26'd0, take};
    // Full only when the final rate byte is written; a short last
    // word leaves the block open for the pad byte.
    assign block_full = (byte_next == rate_bytes);

    assign word_base = {word_idx, 6'd0};
    assign pad_base  = {byte_idx, 3'd0};
    assign end_base  = {last_byte, 3'd0};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (hdr_acc) begin
                    state_n = (hdr_len != '0) ? LOAD : PAD;
                end
            end
            LOAD: begin
                if (load_acc && rem_after == '0) begin
                    state_n = PAD;
                end
            end
            PAD: begin
                if (!input_buffer_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        data_ready = 1'b0;
        hdr_acc    = 1'b0;
        load_acc   = 1'b0;
        pad_fire   = 1'b0;
        unique case (state)
            IDLE: begin
                data_ready = !input_buffer_ready &&
                             !last_block_in_buffer;
                hdr_acc    = data_valid && data_ready;
            end
            LOAD: begin
                data_ready = !input_buffer_ready;
                load_acc   = data_valid && data_ready;
            end
            PAD: begin
                pad_fire = !input_buffer_ready;
            end
            default: ;
        endcase
    end

    // Drop bytes beyond the end of the message in the final word.
    always_comb begin
        word_masked = data_in;
        for (int j = 0; j < 8; j++) begin
            if (remaining <= 30'(j)) begin
                word_masked[8*j +: 8] = 8'h00;
            end
        end
    end

    // Datapath next values
    always_comb begin
        rate_n      = rate_output;
        size_n      = output_size;
        mode_n      = operation_mode;
        remaining_n = remaining;
        byte_idx_n  = byte_idx;
        word_idx_n  = word_idx;
        copy_n      = 1'b0;
        // Clears first so a coincident set below wins.
        ibr_n = input_buffer_ready & ~input_buffer_ready_clr;
        lbb_n = last_block_in_buffer & ~last_block_in_buffer_clr;

        unique case (1'b1)
            hdr_acc: begin
                size_n      = hdr_size;
                mode_n      = hdr_mode;
                remaining_n = hdr_len;
                byte_idx_n  = '0;
                word_idx_n  = '0;
                copy_n      = 1'b1;
            end
            load_acc: begin
                // First word of a block wipes stale slots, which also
                // keeps the SHAKE256-unused slots at zero.
                if (word_idx == '0) begin
                    rate_n = '0;
                end
                rate_n[word_base +: WORD_W] = word_masked;
                remaining_n = rem_after;
                if (block_full) begin
                    word_idx_n = '0;
                    byte_idx_n = '0;
                    ibr_n      = 1'b1;
                end else begin
                    word_idx_n = word_idx + 5'd1;
                    byte_idx_n = byte_next;
                end
            end
            pad_fire: begin
                // word_idx = 0 means the pad starts a fresh block.
                if (word_idx == '0) begin
                    rate_n = '0;
                end
                rate_n[pad_base +: 8] = rate_n[pad_base +: 8] | 8'h1F;
                rate_n[end_base +: 8] = rate_n[end_base +: 8] | 8'h80;
                ibr_n = 1'b1;
                lbb_n = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_output          <= '0;
            output_size          <= '0;
            operation_mode       <= '0;
            remaining            <= '0;
            byte_idx             <= '0;
            word_idx             <= '0;
            copy_control_regs_en <= 1'b0;
            input_buffer_ready   <= 1'b0;
            last_block_in_buffer <= 1'b0;
        end else begin
            rate_output          <= rate_n;
            output_size          <= size_n;
            operation_mode       <= mode_n;
            remaining            <= remaining_n;
            byte_idx             <= byte_idx_n;
            word_idx             <= word_idx_n;
            copy_control_regs_en <= copy_n;
            input_buffer_ready   <= ibr_n;
            last_block_in_buffer <= lbb_n;
        end
    end

endmodule

// File: tb/tb_load_stage.sv
// Self-checking bench for load_stage: vector table, hand sequences
// and random messages against a byte-level padding model.

module tb_load_stage;

    localparam int RW = 1344;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   data_in;
    logic          data_valid;
    logic          data_ready;
    logic [RW-1:0] rate_output;
    logic [31:0]   output_size;
    logic [1:0]    operation_mode;
    logic          copy_control_regs_en;
    logic          input_buffer_ready;
    logic          last_block_in_buffer;
    logic          input_buffer_ready_clr;
    logic          last_block_in_buffer_clr;

    always #5 clk = ~clk;

    load_stage dut (
        .clk                      (clk),
        .rst                      (rst),
        .data_in                  (data_in),
        .data_valid               (data_valid),
        .data_ready               (data_ready),
        .rate_output              (rate_output),
        .output_size              (output_size),
        .operation_mode           (operation_mode),
        .copy_control_regs_en     (copy_control_regs_en),
        .input_buffer_ready       (input_buffer_ready),
        .last_block_in_buffer     (last_block_in_buffer),
        .input_buffer_ready_clr   (input_buffer_ready_clr),
        .last_block_in_buffer_clr (last_block_in_buffer_clr)
    );

    int n_pass = 0;
    int n_tot  = 0;

    logic [7:0]    msg_q[$];
    logic [RW-1:0] blk_q[$];
    bit            lst_q[$];

    typedef struct {
        logic [1:0]  mode;
        int          size;
        logic [31:0] osz;
        int          exp_blocks;
        int          pad_idx;
        logic [7:0]  pad_val;
    } vec_t;

    vec_t vecs[10];

    logic [RW-1:0] snap;
    logic [RW-1:0] want;

    task automatic chk(input string name,
                       input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int rate_of(input logic [1:0] m);
        return (m == 2'b00) ? 168 : 136;
    endfunction

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send_word(input logic [63:0] w);
        int n;
        n = 0;
        data_in    = w;
        data_valid = 1'b1;
        while (!data_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_handshake", n < 200, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_block();
        int n;
        n = 0;
        while (!input_buffer_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("block_timeout", n < 200, 1'b1);
    endtask

    task automatic clear_flags();
        input_buffer_ready_clr   = 1'b1;
        last_block_in_buffer_clr = 1'b1;
        @(negedge clk);
        input_buffer_ready_clr   = 1'b0;
        last_block_in_buffer_clr = 1'b0;
    endtask

    // Streams msg_q as one message, drains every block, then compares
    // against blocks built from the sponge padding rule on bytes.
    task automatic run_msg(input logic [1:0]  mode,
                           input int          size,
                           input logic [31:0] osz,
                           input logic [7:0]  fill,
                           input bit          gaps);
        logic [63:0]   words[$];
        logic [63:0]   wd;
        logic [7:0]    pad[$];
        logic [RW-1:0] exp_blk;
        int nw, idx, cyc, copies, rb, nb, k;
        bit done;

        words.push_back({mode, 30'(size), osz});
        nw = (size + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            for (int j = 0; j < 8; j++) begin
                k = 8 * w + j;
                wd[8*j +: 8] = (k < size) ? msg_q[k] : fill;
            end
            words.push_back(wd);
        end

        blk_q.delete();
        lst_q.delete();
        idx = 0;
        cyc = 0;
        copies = 0;
        done = 1'b0;
        while (!done && cyc < 5000) begin
            if (copy_control_regs_en) begin
                copies++;
                chk("copy_size", output_size, osz);
                chk("copy_mode", operation_mode, mode);
            end
            if (input_buffer_ready) begin
                blk_q.push_back(rate_output);
                lst_q.push_back(last_block_in_buffer);
                input_buffer_ready_clr   = 1'b1;
                last_block_in_buffer_clr = last_block_in_buffer;
                if (last_block_in_buffer) done = 1'b1;
            end else begin
                input_buffer_ready_clr   = 1'b0;
                last_block_in_buffer_clr = 1'b0;
            end
            if (idx < words.size() &&
                !(gaps && $urandom_range(0, 3) == 0)) begin
                data_valid = 1'b1;
                data_in    = words[idx];
            end else begin
                data_valid = 1'b0;
                data_in    = {$urandom, $urandom};
            end
            if (data_valid && data_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        data_valid               = 1'b0;
        input_buffer_ready_clr   = 1'b0;
        last_block_in_buffer_clr = 1'b0;
        chk("msg_done", done, 1'b1);
        chk("idle_ready", data_ready, 1'b1);
        chk("copy_count", copies, 1);

        rb = rate_of(mode);
        foreach (msg_q[i]) pad.push_back(msg_q[i]);
        pad.push_back(8'h1F);
        while (pad.size() % rb != 0) pad.push_back(8'h00);
        pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
        nb = pad.size() / rb;
        chk("block_count", blk_q.size(), nb);
        for (int b = 0; b < nb && b < blk_q.size(); b++) begin
            exp_blk = '0;
            for (int q = 0; q < rb; q++) begin
                exp_blk[8*q +: 8] = pad[b*rb + q];
            end
            chk("block_data", blk_q[b], exp_blk);
            chk("last_flag", lst_q[b], (b == nb - 1));
        end
    endtask

    initial begin
        vecs[0] = '{2'b00,   0, 32'd256, 1,   0, 8'h1F};
        vecs[1] = '{2'b01,   3, 32'd512, 1,   3, 8'h1F};
        vecs[2] = '{2'b00, 167, 32'd32,  1, 167, 8'h9F};
        vecs[3] = '{2'b00, 168, 32'd64,  2,   0, 8'h1F};
        vecs[4] = '{2'b01, 136, 32'd1,   2,   0, 8'h1F};
        vecs[5] = '{2'b10, 135, 32'd7,   1, 135, 8'h9F};
        vecs[6] = '{2'b11, 300, 32'd99,  3,  28, 8'h1F};
        vecs[7] = '{2'b00, 200, 32'd5,   2,  32, 8'h1F};
        vecs[8] = '{2'b01,   8, 32'd0,   1,   8, 8'h1F};
        vecs[9] = '{2'b00,   1, 32'd1,   1,   1, 8'h1F};

        rst                      = 1'b1;
        data_in                  = '0;
        data_valid               = 1'b0;
        input_buffer_ready_clr   = 1'b0;
        last_block_in_buffer_clr = 1'b0;

        #1;
        chk("rst_rate", rate_output, '0);
        chk("rst_size", output_size, '0);
        chk("rst_mode", operation_mode, '0);
        chk("rst_copy", copy_control_regs_en, 1'b0);
        chk("rst_ibr", input_buffer_ready, 1'b0);
        chk("rst_lbb", last_block_in_buffer, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", data_ready, 1'b1);

        // Short SHAKE256 message with garbage above the length.
        msg_q = '{8'hCC, 8'hBB, 8'hAA};
        run_msg(2'b01, 3, 32'd0, 8'hFF, 1'b0);
        chk("s3_low", blk_q[0][31:0], 32'h1FAA_BBCC);
        chk("s3_end", blk_q[0][8*135 +: 8], 8'h80);
        chk("s3_hi_zero", blk_q[0][1343:1088], '0);
        chk("s3_last", lst_q[0], 1'b1);

        // Backpressure across a full SHAKE128 block.
        send_word({2'b00, 30'd200, 32'd77});
        chk("bp_copy", copy_control_regs_en, 1'b1);
        chk("bp_copy_size", output_size, 32'd77);
        for (int w = 0; w < 21; w++) begin
            send_word(64'h0101_0101_0101_0101 * 64'(w + 1));
            if (w == 0) chk("bp_copy_drop", copy_control_regs_en, 1'b0);
        end
        chk("bp_full", input_buffer_ready, 1'b1);
        chk("bp_not_last", last_block_in_buffer, 1'b0);
        chk("bp_word20", rate_output[1343:1280],
            64'h0101_0101_0101_0101 * 64'd21);
        snap       = rate_output;
        data_in    = 64'hDEAD_BEEF_CAFE_F00D;
        data_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_ready", data_ready, 1'b0);
        end
        chk("bp_stable", rate_output, snap);
        input_buffer_ready_clr = 1'b1;
        @(negedge clk);
        input_buffer_ready_clr = 1'b0;
        chk("bp_clr", input_buffer_ready, 1'b0);
        chk("bp_ready_after", data_ready, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        want       = '0;
        want[63:0] = 64'hDEAD_BEEF_CAFE_F00D;
        chk("bp_accept", rate_output, want);
        for (int w = 0; w < 3; w++) begin
            send_word({$urandom, $urandom});
        end
        wait_block();
        chk("bp_pad_last", last_block_in_buffer, 1'b1);
        chk("bp_pad_byte", rate_output[8*32 +: 8], 8'h1F);
        chk("bp_end_byte", rate_output[8*167 +: 8], 8'h80);
        chk("bp_keep", rate_output[63:0], 64'hDEAD_BEEF_CAFE_F00D);
        clear_flags();
        chk("bp_idle", data_ready, 1'b1);

        // Reset in the middle of a message.
        send_word({2'b00, 30'd100, 32'd9});
        for (int w = 0; w < 5; w++) begin
            send_word({$urandom, $urandom});
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_rate", rate_output, '0);
        chk("mid_rst_size", output_size, '0);
        chk("mid_rst_flags",
            {copy_control_regs_en, input_buffer_ready,
             last_block_in_buffer, operation_mode}, '0);
        chk("mid_rst_ready", data_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        msg_q.delete();
        run_msg(2'b00, 0, 32'd256, 8'h00, 1'b0);
        chk("mid_rst_pad", blk_q[0][7:0], 8'h1F);

        // Vector table
        for (int v = 0; v < 10; v++) begin
            msg_q.delete();
            for (int i = 0; i < vecs[v].size; i++) begin
                msg_q.push_back(8'($urandom));
            end
            run_msg(vecs[v].mode, vecs[v].size, vecs[v].osz,
                    8'($urandom), 1'b0);
            chk("vec_blocks", blk_q.size(), vecs[v].exp_blocks);
            chk("vec_pad",
                blk_q[blk_q.size()-1][8*vecs[v].pad_idx +: 8],
                vecs[v].pad_val);
        end

        // Random messages with stalls
        repeat (30) begin
            logic [1:0] m;
            int         sz;
            m  = 2'($urandom_range(0, 3));
            sz = $urandom_range(0, 400);
            msg_q.delete();
            for (int i = 0; i < sz; i++) begin
                msg_q.push_back(8'($urandom));
            end
            run_msg(m, sz, $urandom, 8'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
